// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, line levels and default width.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA      = 3'd1;
  localparam logic [2:0] PARITY    = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_sipo.sv
// Serial-in parallel-out register for the UART receiver.
// The first bit shifted in ends up at bit 0 after DATA_WIDTH shifts (LSB-first line order).
module rx_sipo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] data
);

  // New bits enter at the MSB end and walk down towards bit 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {bit_in, data[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: start bit, DATA_WIDTH data bits LSB first, parity, stop.
// One sample per Baud_Clk edge, no oversampling.
// Optional UART_RX_SYNC_EN: adds a 2-flop input synchronizer (reset to line idle),
// which delays every sample and Rx_valid by two cycles.
//
// state     | meaning
// IDLE      | waiting for a start bit (line low)
// DATA      | shifting in DATA_WIDTH payload bits
// PARITY    | capturing parity bit, computing mismatch
// STOP      | sampling stop bit, publishing word and flags
// WAIT_IDLE | stop bit was low; ignore line until it returns high
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  Baud_Clk,
  input  logic                  Reset,
  input  logic                  Rx_dataIn,
  output logic [DATA_WIDTH-1:0] Rx_dataOut,
  output logic                  Rx_valid,
  output logic                  Parity_Err,
  output logic                  Frame_Err,
  output logic                  Busy
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic                  rx_bit;
  logic [2:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  parity_mismatch;
  logic                  sipo_clear;
  logic                  sipo_shift;
  logic [DATA_WIDTH-1:0] shift_q;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer; resets to idle level so reset never looks like a start bit.
  always_ff @(posedge Baud_Clk) begin
    if (Reset) begin
      sync_q <= {2{LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[0], Rx_dataIn};
    end
  end

  assign rx_bit = sync_q[1];
`else
  assign rx_bit = Rx_dataIn;
`endif

  assign sipo_clear = (state == IDLE) && (rx_bit == START_BIT);
  assign sipo_shift = (state == DATA);
  assign Busy       = (state != IDLE);

  rx_sipo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sipo (
    .clk     (Baud_Clk),
    .reset   (Reset),
    .clear   (sipo_clear),
    .shift_en(sipo_shift),
    .bit_in  (rx_bit),
    .data    (shift_q)
  );

  // Frame sequencing, bit counting and parity evaluation.
  always_ff @(posedge Baud_Clk) begin
    if (Reset) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      parity_mismatch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state <= PARITY;
          end
        end
        PARITY: begin
          // The shift register holds the complete payload by now.
          parity_mismatch <= rx_bit ^ (^shift_q) ^ PARITY_ODD;
          state           <= STOP;
        end
        STOP: begin
          state <= (rx_bit == STOP_BIT) ? IDLE : WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (rx_bit == LINE_IDLE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output word and single-cycle result strobes, published on the stop-bit edge.
  always_ff @(posedge Baud_Clk) begin
    if (Reset) begin
      Rx_dataOut <= '0;
      Rx_valid   <= 1'b0;
      Parity_Err <= 1'b0;
      Frame_Err  <= 1'b0;
    end else begin
      Rx_valid   <= (state == STOP);
      Parity_Err <= (state == STOP) && parity_mismatch;
      Frame_Err  <= (state == STOP) && (rx_bit != STOP_BIT);
      if (state == STOP) begin
        Rx_dataOut <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a scoreboard of expected frames.
module tb_uart_receiver;

  localparam int DW = 32;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          Baud_Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Rx_dataIn = 1'b1;
  logic [DW-1:0] Rx_dataOut;
  logic          Rx_valid;
  logic          Parity_Err;
  logic          Frame_Err;
  logic          Busy;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  uart_receiver #(
    .DATA_WIDTH(DW),
    .PARITY_ODD(PODD)
  ) dut (
    .Baud_Clk  (Baud_Clk),
    .Reset     (Reset),
    .Rx_dataIn (Rx_dataIn),
    .Rx_dataOut(Rx_dataOut),
    .Rx_valid  (Rx_valid),
    .Parity_Err(Parity_Err),
    .Frame_Err (Frame_Err),
    .Busy      (Busy)
  );

  always #5 Baud_Clk = ~Baud_Clk;

  always @(posedge Baud_Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic good_parity(input logic [DW-1:0] d);
    return (^d) ^ PODD;
  endfunction

  task automatic drive_bit(input logic b);
    @(posedge Baud_Clk);
    #1;
    Rx_dataIn = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Drives one full frame; expectation is queued when the start bit goes out.
  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop_b);
    exp_t e;
    drive_bit(1'b0);
    e.data = d;
    e.perr = (par != good_parity(d));
    e.ferr = ~stop_b;
    e.cyc  = cyc + DW + 3 + SYNC_LAT;
    sb.push_back(e);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop_b);
  endtask

  // Scoreboard monitor: compares every Rx_valid pulse against the queued frame.
  always @(negedge Baud_Clk) begin
    exp_t e;
    if (!Reset) begin
      if (Rx_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_valid: observed pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("rx_data", Rx_dataOut, e.data);
          check("parity_err", 32'(Parity_Err), 32'(e.perr));
          check("frame_err", 32'(Frame_Err), 32'(e.ferr));
          check("valid_cycle", cyc, e.cyc);
        end
      end else begin
        check("flags_idle", {30'd0, Parity_Err, Frame_Err}, 32'd0);
      end
    end
  end

  initial begin
    int wait_cnt;

    // Reset state
    repeat (3) @(posedge Baud_Clk);
    #1;
    check("rst_data", Rx_dataOut, 32'd0);
    check("rst_valid", 32'(Rx_valid), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_perr", 32'(Parity_Err), 32'd0);
    check("rst_ferr", 32'(Frame_Err), 32'd0);
    Reset = 1'b0;
    idle(4);

    // Clean frame, even parity
    send_frame(32'hA5A5F00F, 1'b0, 1'b1);
    idle(6);

    // Parity error
    send_frame(32'h00000001, 1'b0, 1'b1);
    idle(6);

    // Framing error followed by a held-low line
    send_frame(32'h12345678, good_parity(32'h12345678), 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b0);
      check("busy_low_line", 32'(Busy), 32'd1);
    end
    idle(5);
    check("busy_after_release", 32'(Busy), 32'd0);
    check("no_extra_frame", sb.size(), 32'd0);

    // Back-to-back, zero gap
    send_frame(32'hDEADBEEF, good_parity(32'hDEADBEEF), 1'b1);
    send_frame(32'h0F0F0F0F, good_parity(32'h0F0F0F0F), 1'b1);
    idle(6);
    check("b2b_drained", sb.size(), 32'd0);

    // Reset in the middle of a frame
    drive_bit(1'b0);
    for (int i = 0; i <= 10; i++) drive_bit(i[0]);
    @(posedge Baud_Clk);
    #1;
    Reset = 1'b1;
    Rx_dataIn = 1'b1;
    repeat (2) @(posedge Baud_Clk);
    #1;
    Reset = 1'b0;
    check("midrst_data", Rx_dataOut, 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_valid", 32'(Rx_valid), 32'd0);
    idle(40);
    check("midrst_data_hold", Rx_dataOut, 32'd0);
    send_frame(32'hCAFEBABE, good_parity(32'hCAFEBABE), 1'b1);
    idle(6);

    // Loopback-style word with MSB and LSB set
    send_frame(32'h80000001, good_parity(32'h80000001), 1'b1);
    idle(4);
    check("hold_data", Rx_dataOut, 32'h80000001);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 100) begin
      @(posedge Baud_Clk);
      wait_cnt++;
    end
    check("sb_drain", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
